// File: rtl/bcd2bin4digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd2bin4digit
// Purpose  : Sequential 4-digit BCD to 14-bit binary converter. Digits are
//            latched on start and folded into an accumulator one per cycle
//            (thousands first). 4'hF marks a blank digit: leading blanks are
//            skipped, embedded blanks count as zero. 4'hA-4'hE count as zero.
// Options  : `define BCD2BIN_ERR_EN adds the err output, which flags illegal
//            digits and embedded blanks and forces value to zero.
// Revision : 1.0 - initial release
// ============================================================================
module bcd2bin4digit (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  A,
  input  logic [3:0]  B,
  input  logic [3:0]  C,
  input  logic [3:0]  D,
  input  logic        start,
  output logic [13:0] value,
  output logic        done,
`ifdef BCD2BIN_ERR_EN
  output logic        err,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_dig;    // latched digits, current digit in the top nibble
  logic [13:0] r_acc;
  logic [1:0]  r_idx;
  logic        r_seen;   // a non-blank digit has been processed
`ifdef BCD2BIN_ERR_EN
  logic        r_bad;    // sticky: illegal digit or embedded blank seen
`endif

  logic [3:0]  w_digit;
  logic        w_blank;
  logic        w_legal;
  logic [3:0]  w_term;
  logic [13:0] w_next_acc;

  // Decode the digit being folded in this cycle and form the next accumulator
  always_comb begin
    w_digit    = r_dig[15:12];
    w_blank    = (w_digit == 4'hF);
    w_legal    = (w_digit <= 4'd9);
    w_term     = w_legal ? w_digit : 4'd0;
    // Leading blanks leave the accumulator untouched; anything else is acc*10+term
    if (w_blank && !r_seen)
      w_next_acc = r_acc;
    else
      w_next_acc = (r_acc << 3) + (r_acc << 1) + {10'd0, w_term};
  end

  // Control FSM with registered outputs: IDLE -> ACC x4 -> FIN -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dig   <= 16'd0;
      r_acc   <= 14'd0;
      r_idx   <= 2'd0;
      r_seen  <= 1'b0;
      value   <= 14'd0;
      done    <= 1'b0;
      busy    <= 1'b0;
`ifdef BCD2BIN_ERR_EN
      r_bad   <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      // busy trails the state by one cycle so it covers the done cycle too
      busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dig   <= {A, B, C, D};
            r_acc   <= 14'd0;
            r_idx   <= 2'd0;
            r_seen  <= 1'b0;
`ifdef BCD2BIN_ERR_EN
            r_bad   <= 1'b0;
`endif
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc <= w_next_acc;
          r_dig <= {r_dig[11:0], 4'h0};
          r_idx <= r_idx + 2'd1;
          if (!w_blank)
            r_seen <= 1'b1;
`ifdef BCD2BIN_ERR_EN
          if ((!w_legal && !w_blank) || (w_blank && r_seen))
            r_bad <= 1'b1;
`endif
          if (r_idx == 2'd3)
            r_state <= S_FIN;
        end
        S_FIN: begin
`ifdef BCD2BIN_ERR_EN
          value <= r_bad ? 14'd0 : r_acc;
          err   <= r_bad;
`else
          value <= r_acc;
`endif
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin4digit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd2bin4digit
// Purpose  : Scoreboard bench for bcd2bin4digit. Stimulus pushes expected
//            results computed from a positional-weight reference model; a
//            negedge monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd2bin4digit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  A = 4'd0, B = 4'd0, C = 4'd0, D = 4'd0;
  logic [13:0] value;
  logic        done;
  logic        busy;
`ifdef BCD2BIN_ERR_EN
  logic        err;
`endif

  bcd2bin4digit dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .start (start),
    .value (value),
    .done  (done),
`ifdef BCD2BIN_ERR_EN
    .err   (err),
`endif
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    bit e;
    int acc_cyc;   // edge at which start is sampled
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: each position has a decimal weight; blanks and A-E weigh nothing
  function automatic void model(input logic [3:0] a, b, c, d, output int v, output bit e);
    logic [3:0] dg [4];
    int w [4];
    bit seen;
    dg = '{a, b, c, d};
    w  = '{1000, 100, 10, 1};
    v = 0; e = 0; seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (dg[i] <= 4'd9) v += w[i] * int'(dg[i]);
      if (dg[i] == 4'hF) begin
        if (seen) e = 1;
      end else begin
        seen = 1;
        if (dg[i] > 4'd9) e = 1;
      end
    end
`ifdef BCD2BIN_ERR_EN
    if (e) v = 0;
`endif
  endfunction

  task automatic push_exp(input logic [3:0] a, b, c, d);
    exp_t x;
    model(a, b, c, d, x.val, x.e);
    x.acc_cyc = cyc + 1;
    q.push_back(x);
  endtask

  // Called just after a rising edge; start is sampled at the next edge.
  // gap=1 gives a back-to-back start on the first acceptable edge.
  task automatic conv(input logic [3:0] a, b, c, d, input int gap);
    A = a; B = b; C = c; D = d;
    start = 1'b1;
    push_exp(a, b, c, d);
    @(posedge clk); #1;
    start = 1'b0;
    // scramble inputs while busy; latched digits must be used
    A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 4'($urandom);
    repeat (4 + gap) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations on done, checks latency, busy length, value hold
  int run = 0;
  int last_val = 0;
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      run = 0;
      last_val = 0;
    end else begin
      if (busy) run++;
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          x = q.pop_front();
          chk("value", 32'(value), 32'(x.val));
          chk("latency", 32'(cyc), 32'(x.acc_cyc + 5));
          chk("busy_len", 32'(run), 32'd5);
`ifdef BCD2BIN_ERR_EN
          chk("err", 32'(err), 32'(x.e));
`endif
          last_val = x.val;
        end
        run = 0;
      end else begin
        chk("value_hold", 32'(value), 32'(last_val));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
`ifdef BCD2BIN_ERR_EN
    chk("rst_err",   32'(err),   32'd0);
`endif
    rst = 1'b0;

    // first start at the very first edge with reset released
    conv(4'h1, 4'h2, 4'h3, 4'h4, 1);
    conv(4'hF, 4'hF, 4'h4, 4'h2, 1);
    conv(4'hF, 4'hF, 4'hF, 4'hF, 1);
    conv(4'h9, 4'h9, 4'h9, 4'h9, 1);
    conv(4'h1, 4'hC, 4'h3, 4'h4, 1);
    conv(4'h1, 4'hF, 4'h3, 4'h4, 1);
    conv(4'hF, 4'h5, 4'h0, 4'h7, 2);

    // start re-pulsed while busy with new digits: must be ignored
    A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4;
    start = 1'b1;
    push_exp(4'h1, 4'h2, 4'h3, 4'h4);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    A = 4'h0; B = 4'h0; C = 4'h0; D = 4'h0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // reset in the middle of a conversion abandons it
    A = 4'h8; B = 4'h7; C = 4'h6; D = 4'h5;
    start = 1'b1;
    push_exp(4'h8, 4'h7, 4'h6, 4'h5);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(q.pop_back());
    @(negedge clk);
    chk("midrst_value", 32'(value), 32'd0);
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_done",  32'(done),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    conv(4'h2, 4'h0, 4'h2, 4'h5, 1);

    // randomized conversions with random idle gaps
    for (int i = 0; i < 60; i++) begin
      conv(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           int'($urandom_range(1, 3)));
    end

    // bounded drain of outstanding expectations
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
